// File: rtl/pport_pcint.sv
// ---------------------------------------------------------------------------
// pport_pcint - parallel I/O port with pin-change interrupt for the AVR I/O space
//
// Implements a width-parametrised bidirectional port:
//   PORTX (output data), DDRX (direction), PINX (resynchronised pad inputs).
// Adds per-bit pin-change detection:
//   PCMSK (mask), PCIFR (sticky flags, write-1-to-clear),
//   and a single irq/irqack handshake.
//
// Optional build macro:
//   PPORT_PCINT_PIN_TOGGLE_EN - when defined, a write to PINX XORs PORTX with
//                               the written data (toggle outputs written with 1).
//                               When undefined, PINX writes are ignored.
//
// Ports:
//   cp2        in   core clock
//   ireset     in   synchronous active-low reset
//   adr        in   [5:0] I/O address
//   dbus_in    in   [7:0] I/O write data
//   dbus_out   out  [7:0] I/O read data, 0 when no register is addressed
//   iore       in   I/O read strobe
//   iowe       in   I/O write strobe
//   io_out_en  out  iore and one of the five port addresses matched
//   irq        out  pin-change interrupt request (registered OR of PCIFR)
//   irqack     in   interrupt acknowledge, clears every flag
//   portx      out  [port_width-1:0] output data to pads
//   ddrx       out  [port_width-1:0] direction, 1 = output
//   pinx       in   [port_width-1:0] asynchronous pad inputs
//   resync_out out  [port_width-1:0] resynchronised pin value (PINX contents)
// ---------------------------------------------------------------------------
module pport_pcint #(
  parameter logic [5:0] portx_adr  = 6'h00,
  parameter logic [5:0] ddrx_adr   = 6'h01,
  parameter logic [5:0] pinx_adr   = 6'h02,
  parameter logic [5:0] pcmsk_adr  = 6'h03,
  parameter logic [5:0] pcifr_adr  = 6'h04,
  parameter int         port_width = 8,
  parameter int         rs_stages  = 2
) (
  input  logic                  cp2,
  input  logic                  ireset,
  input  logic [5:0]            adr,
  input  logic [7:0]            dbus_in,
  output logic [7:0]            dbus_out,
  input  logic                  iore,
  input  logic                  iowe,
  output logic                  io_out_en,
  output logic                  irq,
  input  logic                  irqack,
  output logic [port_width-1:0] portx,
  output logic [port_width-1:0] ddrx,
  input  logic [port_width-1:0] pinx,
  output logic [port_width-1:0] resync_out
);

  localparam int         PW        = port_width;
  // The counter must run long enough for the sync chain and pin_prev to fill.
  localparam logic [2:0] PRIME_MAX = 3'(rs_stages + 1);

  logic [PW-1:0]                portx_reg;
  logic [PW-1:0]                ddrx_reg;
  logic [PW-1:0]                pcmsk_reg;
  logic [PW-1:0]                pcifr_reg;
  logic [PW-1:0]                pcifr_next;
  logic [PW-1:0]                pin_prev_reg;
  logic [rs_stages-1:0][PW-1:0] sync_reg;
  logic [2:0]                   prime_cnt_reg;
  logic                         irq_reg;

  logic          primed;
  logic [PW-1:0] chg;
  logic [PW-1:0] clr;
  logic [PW-1:0] wdata;
  logic [7:0]    rd_data;

  logic sel_portx, sel_ddrx, sel_pinx, sel_pcmsk, sel_pcifr;
  logic wr_portx, wr_ddrx, wr_pcmsk, wr_pcifr;
  logic dbus_unused;

  assign sel_portx = (adr == portx_adr);
  assign sel_ddrx  = (adr == ddrx_adr);
  assign sel_pinx  = (adr == pinx_adr);
  assign sel_pcmsk = (adr == pcmsk_adr);
  assign sel_pcifr = (adr == pcifr_adr);

  assign wr_portx = iowe & sel_portx;
  assign wr_ddrx  = iowe & sel_ddrx;
  assign wr_pcmsk = iowe & sel_pcmsk;
  assign wr_pcifr = iowe & sel_pcifr;

  // Only the implemented bits of the write bus reach the registers.
  assign wdata       = dbus_in[PW-1:0];
  assign dbus_unused = ^dbus_in;

  assign primed     = (prime_cnt_reg == PRIME_MAX);
  assign resync_out = sync_reg[rs_stages-1];

  // Per-bit change detection and flag update; a new change beats a clear.
  for (genvar gi = 0; gi < PW; gi++) begin : g_bit
    assign chg[gi]        = (resync_out[gi] ^ pin_prev_reg[gi]) & pcmsk_reg[gi] & primed;
    assign clr[gi]        = (wr_pcifr & dbus_in[gi]) | irqack;
    assign pcifr_next[gi] = (pcifr_reg[gi] & ~clr[gi]) | chg[gi];
  end

  always_ff @(posedge cp2) begin
    if (!ireset) begin
      portx_reg     <= '0;
      ddrx_reg      <= '0;
      pcmsk_reg     <= '0;
      pcifr_reg     <= '0;
      pin_prev_reg  <= '0;
      sync_reg      <= '0;
      prime_cnt_reg <= '0;
      irq_reg       <= 1'b0;
    end else begin
      if (wr_portx) begin
        portx_reg <= wdata;
      end
`ifdef PPORT_PCINT_PIN_TOGGLE_EN
      else if (iowe && sel_pinx) begin
        portx_reg <= portx_reg ^ wdata;
      end
`endif
      if (wr_ddrx) begin
        ddrx_reg <= wdata;
      end
      if (wr_pcmsk) begin
        pcmsk_reg <= wdata;
      end

      sync_reg[0] <= pinx;
      for (int i = 1; i < rs_stages; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end

      pin_prev_reg <= resync_out;

      if (!primed) begin
        prime_cnt_reg <= prime_cnt_reg + 3'd1;
      end

      pcifr_reg <= pcifr_next;
      // irq follows the flags one cycle later.
      irq_reg   <= |pcifr_reg;
    end
  end

  // Combinational read mux, zero-extended to the 8-bit bus.
  always_comb begin
    rd_data = '0;
    if (sel_portx) begin
      rd_data[PW-1:0] = portx_reg;
    end else if (sel_ddrx) begin
      rd_data[PW-1:0] = ddrx_reg;
    end else if (sel_pinx) begin
      rd_data[PW-1:0] = resync_out;
    end else if (sel_pcmsk) begin
      rd_data[PW-1:0] = pcmsk_reg;
    end else if (sel_pcifr) begin
      rd_data[PW-1:0] = pcifr_reg;
    end
  end

  assign dbus_out  = rd_data;
  assign io_out_en = iore & (sel_portx | sel_ddrx | sel_pinx | sel_pcmsk | sel_pcifr);
  assign irq       = irq_reg;
  assign portx     = portx_reg;
  assign ddrx      = ddrx_reg;

endmodule

// File: tb/tb_pport_pcint.sv
// ---------------------------------------------------------------------------
// tb_pport_pcint - directed self-checking bench for pport_pcint.
// dut  : port_width=8, rs_stages=2 (main pin-change tests)
// dut6 : port_width=6, rs_stages=2 (truncated register widths)
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (or 1 ns after it for combinational reads).
// ---------------------------------------------------------------------------
module tb_pport_pcint;

  localparam logic [5:0] A_PORTX = 6'h00;
  localparam logic [5:0] A_DDRX  = 6'h01;
  localparam logic [5:0] A_PINX  = 6'h02;
  localparam logic [5:0] A_PCMSK = 6'h03;
  localparam logic [5:0] A_PCIFR = 6'h04;

`ifdef PPORT_PCINT_PIN_TOGGLE_EN
  localparam logic [7:0] TOGGLE_EXP = 8'h0C;
`else
  localparam logic [7:0] TOGGLE_EXP = 8'h0F;
`endif

  logic       cp2;
  logic       ireset;
  logic [5:0] adr;
  logic [7:0] dbus_in;
  logic       iore;
  logic       iowe;
  logic       irqack;

  logic [7:0] pinx;
  logic [7:0] dbus_out;
  logic       io_out_en;
  logic       irq;
  logic [7:0] portx;
  logic [7:0] ddrx;
  logic [7:0] resync_out;

  logic [5:0] pinx6;
  logic [7:0] dbus_out6;
  logic       io_out_en6;
  logic       irq6;
  logic [5:0] portx6;
  logic [5:0] ddrx6;
  logic [5:0] resync_out6;

  int checks = 0;
  int errors = 0;

  logic [7:0] rd;
  logic [7:0] rd6;

  pport_pcint #(.port_width(8), .rs_stages(2)) dut (
    .cp2(cp2), .ireset(ireset), .adr(adr), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .iore(iore), .iowe(iowe), .io_out_en(io_out_en), .irq(irq), .irqack(irqack),
    .portx(portx), .ddrx(ddrx), .pinx(pinx), .resync_out(resync_out)
  );

  pport_pcint #(.port_width(6), .rs_stages(2)) dut6 (
    .cp2(cp2), .ireset(ireset), .adr(adr), .dbus_in(dbus_in), .dbus_out(dbus_out6),
    .iore(iore), .iowe(iowe), .io_out_en(io_out_en6), .irq(irq6), .irqack(irqack),
    .portx(portx6), .ddrx(ddrx6), .pinx(pinx6), .resync_out(resync_out6)
  );

  initial cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(negedge cp2);
  endtask

  // One I/O write, captured on the next rising edge; returns at the following falling edge.
  task automatic io_write(input logic [5:0] a, input logic [7:0] d);
    adr     = a;
    dbus_in = d;
    iowe    = 1'b1;
    @(negedge cp2);
    iowe    = 1'b0;
  endtask

  task automatic io_read(input logic [5:0] a, output logic [7:0] d, output logic [7:0] d6);
    adr  = a;
    iore = 1'b1;
    #1;
    d    = dbus_out;
    d6   = dbus_out6;
    iore = 1'b0;
  endtask

  initial begin
    ireset  = 1'b0;
    adr     = '0;
    dbus_in = '0;
    iore    = 1'b0;
    iowe    = 1'b0;
    irqack  = 1'b0;
    pinx    = 8'hFF;
    pinx6   = '0;

    // Reset with the pins already high.
    step(); step();
    ireset = 1'b1;
    io_read(A_PORTX, rd, rd6); check("rst_portx", rd, 8'h00);
    io_read(A_DDRX,  rd, rd6); check("rst_ddrx",  rd, 8'h00);
    io_read(A_PINX,  rd, rd6); check("rst_pinx",  rd, 8'h00);
    io_read(A_PCMSK, rd, rd6); check("rst_pcmsk", rd, 8'h00);
    io_read(A_PCIFR, rd, rd6); check("rst_pcifr", rd, 8'h00);
    check("rst_irq", irq, 1'b0);
    adr = A_PCIFR; iore = 1'b1; #1;
    check("io_out_en_hit", io_out_en, 1'b1);
    adr = 6'h05; #1;
    check("io_out_en_miss", io_out_en, 1'b0);
    check("dbus_out_miss", dbus_out, 8'h00);
    iore = 1'b0;

    // Priming: full mask in the first cycle after reset must not flag the pipeline fill.
    io_write(A_PCMSK, 8'hFF);
    step(); step(); step(); step();
    io_read(A_PCIFR, rd, rd6); check("prime_pcifr", rd, 8'h00);
    io_read(A_PINX,  rd, rd6); check("prime_pinx",  rd, 8'hFF);
    check("prime_irq", irq, 1'b0);
    io_write(A_PCMSK, 8'h00);
    pinx = 8'h00;
    step(); step(); step(); step();

    // Register readback, including width truncation on the 6-bit port.
    io_write(A_PORTX, 8'hA5);
    io_write(A_DDRX,  8'h0F);
    io_read(A_PORTX, rd, rd6);
    check("rb_portx8", rd, 8'hA5);
    check("rb_portx6", rd6, 8'h25);
    io_read(A_DDRX, rd, rd6);
    check("rb_ddrx6", rd6, 8'h0F);
    check("pad_portx6", portx6, 6'h25);
    check("pad_ddrx6", ddrx6, 6'h0F);

    // Resync and flag latency.
    io_write(A_PCMSK, 8'h01);
    step();
    pinx = 8'h01;                               // before edge k
    step(); check("sync_k", resync_out, 8'h00);
    step(); check("sync_k1", resync_out, 8'h01);
    io_read(A_PINX,  rd, rd6); check("sync_pinx_k1",  rd, 8'h01);
    io_read(A_PCIFR, rd, rd6); check("sync_pcifr_k1", rd, 8'h00);
    step();
    io_read(A_PCIFR, rd, rd6); check("flag_pcifr_k2", rd, 8'h01);
    check("flag_irq_k2", irq, 1'b0);
    step(); check("flag_irq_k3", irq, 1'b1);
    io_write(A_PCIFR, 8'h01);
    io_read(A_PCIFR, rd, rd6); check("w1c_pcifr", rd, 8'h00);
    step(); check("w1c_irq", irq, 1'b0);

    // Mask: bit0 change ignored, bit1 change flagged.
    io_write(A_PCMSK, 8'h02);
    pinx = 8'h00;
    step(); step(); step(); step();
    io_read(A_PCIFR, rd, rd6); check("mask_off", rd, 8'h00);
    pinx = 8'h02;
    step(); step(); step();
    io_read(A_PCIFR, rd, rd6); check("mask_on", rd, 8'h02);

    // Clear/set collision on bit0.
    io_write(A_PCMSK, 8'h03);
    pinx = 8'h03;
    step(); step(); step();
    io_read(A_PCIFR, rd, rd6); check("coll_pre", rd, 8'h03);
    pinx = 8'h02;                               // before edge k
    step(); step();                             // edges k, k+1
    io_write(A_PCIFR, 8'h01);                   // edge k+2, chg on bit0
    io_read(A_PCIFR, rd, rd6); check("coll_set_wins", rd, 8'h03);
    io_write(A_PCIFR, 8'h03);
    io_read(A_PCIFR, rd, rd6); check("coll_clear", rd, 8'h00);
    check("coll_irq_hold", irq, 1'b1);
    step(); check("coll_irq_fall", irq, 1'b0);

    // irqack clears every flag.
    io_write(A_PCMSK, 8'h81);
    pinx = 8'h83;
    step(); step(); step(); step();
    io_read(A_PCIFR, rd, rd6); check("ack_pre", rd, 8'h81);
    check("ack_irq_pre", irq, 1'b1);
    irqack = 1'b1;
    step();
    irqack = 1'b0;
    io_read(A_PCIFR, rd, rd6); check("ack_pcifr", rd, 8'h00);
    check("ack_irq_hold", irq, 1'b1);
    step(); check("ack_irq_fall", irq, 1'b0);

    // PINX write toggle (build-dependent).
    io_write(A_PORTX, 8'h0F);
    io_write(A_PINX,  8'h03);
    io_read(A_PORTX, rd, rd6);
    check("toggle_rd8", rd, TOGGLE_EXP);
    check("toggle_rd6", rd6, TOGGLE_EXP);
    check("toggle_pad", portx, TOGGLE_EXP);

    // Reset while an irq is pending.
    pinx = 8'h82;
    step(); step(); step(); step();
    check("midrst_irq_pre", irq, 1'b1);
    ireset = 1'b0;
    step();
    ireset = 1'b1;
    check("midrst_irq", irq, 1'b0);
    io_read(A_PCIFR, rd, rd6); check("midrst_pcifr", rd, 8'h00);
    io_read(A_PCMSK, rd, rd6); check("midrst_pcmsk", rd, 8'h00);
    check("midrst_portx", portx, 8'h00);
    check("dut6_irq", irq6, 1'b0);
    check("dut6_resync", resync_out6, 6'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
